// File: rtl/param_fifo_if.sv
// Valid/ready word channel used on both sides of param_fifo.
// The master drives val/data and the slave drives rdy.
interface param_fifo_if #(
   parameter int WIDTH = 32
);
   logic             val;
   logic             rdy;
   logic [WIDTH-1:0] data;

   modport master (output val, output data, input rdy);
   modport slave  (input val, input data, output rdy);
endinterface

// File: rtl/param_fifo.sv
// First-word-fall-through FIFO with a block-RAM store, occupancy count, almost flags and flush.
// Optional high-water-mark register is enabled by defining PARAM_FIFO_HWM_EN.
module param_fifo #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 512,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   flush,
   param_fifo_if.slave            in_if,
   param_fifo_if.master           out_if,
   output logic [$clog2(DEPTH):0] count,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] hwm
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_THRESH);
   localparam logic [AW:0] ONE      = (AW+1)'(1);

   if (WIDTH < 1) begin : g_bad_width
      $error("param_fifo: WIDTH must be at least 1");
   end
   if (DEPTH < 4 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("param_fifo: DEPTH must be a power of two in 4..65536");
   end
   if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH || AF_THRESH < 1) begin : g_bad_thresh
      $error("param_fifo: need 0 <= AE_THRESH < AF_THRESH <= DEPTH and AF_THRESH >= 1");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] o_data_r;
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [AW:0]      count_r;
   logic             o_val_r;

   logic ram_empty;
   logic i_rdy;
   logic wr_en;
   logic rden;
   logic out_hs;

   // The pointer wrap bit distinguishes a full RAM from an empty one.
   assign ram_empty = (wptr == rptr);
   assign i_rdy     = ~srst & ~flush & (count_r != FULL_CNT);
   assign wr_en     = in_if.val & i_rdy;
   assign out_hs    = o_val_r & out_if.rdy;
   assign rden      = ~srst & ~flush & ~ram_empty & (~o_val_r | out_if.rdy);

   assign in_if.rdy    = i_rdy;
   assign out_if.val   = o_val_r;
   assign out_if.data  = o_data_r;
   assign count        = count_r;
   assign almost_full  = (count_r >= AF_CNT);
   assign almost_empty = (count_r <= AE_CNT);

   // Storage and read register carry no reset so they map onto a RAM macro.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wptr[AW-1:0]] <= in_if.data;
      end
      if (rden) begin
         o_data_r <= mem[rptr[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (srst || flush) begin
         wptr    <= '0;
         rptr    <= '0;
         count_r <= '0;
         o_val_r <= 1'b0;
      end else begin
         if (wr_en) begin
            wptr <= wptr + ONE;
         end
         if (rden) begin
            rptr    <= rptr + ONE;
            o_val_r <= 1'b1;
         end else if (ram_empty && out_hs) begin
            o_val_r <= 1'b0;
         end
         case ({wr_en, out_hs})
            2'b10:   count_r <= count_r + ONE;
            2'b01:   count_r <= count_r - ONE;
            default: count_r <= count_r;
         endcase
      end
   end

`ifdef PARAM_FIFO_HWM_EN
   logic [AW:0] hwm_r;

   // Tracks the registered count, so the mark trails count by one edge; flush leaves it alone.
   always_ff @(posedge clk) begin
      if (srst) begin
         hwm_r <= '0;
      end else if (count_r > hwm_r) begin
         hwm_r <= count_r;
      end
   end

   assign hwm = hwm_r;
`else
   assign hwm = '0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo at DEPTH=16: directed fill/stream/flush/reset cases plus random traffic.
// A negedge monitor keeps a count model and an expected-data queue, independent of the stimulus.
module tb_param_fifo;

   localparam int W = 16;
   localparam int D = 16;

   logic        clk;
   logic        srst;
   logic        flush;
   logic [4:0]  count;
   logic        almost_full;
   logic        almost_empty;
   logic [4:0]  hwm;

   param_fifo_if #(.WIDTH(W)) in_if ();
   param_fifo_if #(.WIDTH(W)) out_if ();

   param_fifo #(
      .WIDTH(W),
      .DEPTH(D),
      .AF_THRESH(12),
      .AE_THRESH(4)
   ) dut (
      .clk(clk),
      .srst(srst),
      .flush(flush),
      .in_if(in_if),
      .out_if(out_if),
      .count(count),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
      .hwm(hwm)
   );

   int          total = 0;
   int          bad = 0;
   int          mcount = 0;
   int          out_n = 0;
   bit          mon_en = 0;
   logic [W-1:0] exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic [W-1:0] d, input logic r);
      in_if.val  = v;
      in_if.data = d;
      out_if.rdy = r;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drain();
      int n;
      n = 0;
      apply_stimulus(1'b0, '0, 1'b1);
      while ((count != 0 || out_if.val) && n < 100) begin
         step();
         n++;
      end
      total++;
      if (n >= 100) begin
         bad++;
         $display("[TB] FAIL drain_timeout: count=%0d expected 0", count);
      end
      apply_stimulus(1'b0, '0, 1'b0);
   endtask

   // Monitor: checks count/flags/i_rdy against the model and data order against the queue.
   always @(negedge clk) begin
      if (mon_en) begin
         logic in_hs;
         logic o_hs;
         logic [W-1:0] e;
         in_hs = in_if.val & in_if.rdy;
         o_hs  = out_if.val & out_if.rdy & ~srst;
         check_output("count_model", 32'(count), 32'(mcount));
         check_output("almost_full_model", 32'(almost_full), 32'(mcount >= 12));
         check_output("almost_empty_model", 32'(almost_empty), 32'(mcount <= 4));
         check_output("i_rdy_model", 32'(in_if.rdy), 32'(!srst && !flush && mcount != D));
         if (o_hs) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_output: got %0h expected no word", out_if.data);
            end else begin
               e = exp_q.pop_front();
               check_output("o_data_order", 32'(out_if.data), 32'(e));
               out_n++;
            end
         end
         if (in_hs) exp_q.push_back(in_if.data);
         if (srst || flush) begin
            exp_q.delete();
            mcount = 0;
         end else begin
            mcount = mcount + int'(in_hs) - int'(o_hs);
         end
      end
   end

   initial begin
      int start_n;
      logic [4:0] exp_hwm;
      srst  = 1'b1;
      flush = 1'b0;
      apply_stimulus(1'b0, '0, 1'b0);

      // Reset for three cycles
      step();
      mon_en = 1;
      check_output("i_rdy_in_reset", 32'(in_if.rdy), 32'd0);
      step();
      step();
      srst = 1'b0;
      #1;
      check_output("reset_o_val", 32'(out_if.val), 32'd0);
      check_output("reset_count", 32'(count), 32'd0);
      check_output("reset_af", 32'(almost_full), 32'd0);
      check_output("reset_ae", 32'(almost_empty), 32'd1);
      check_output("reset_hwm", 32'(hwm), 32'd0);
      check_output("reset_i_rdy", 32'(in_if.rdy), 32'd1);

      // Single word latency
      apply_stimulus(1'b1, 16'h00A5, 1'b0);
      step();
      apply_stimulus(1'b0, '0, 1'b0);
      check_output("single_o_val_edge1", 32'(out_if.val), 32'd0);
      check_output("single_count_edge1", 32'(count), 32'd1);
      step();
      check_output("single_o_val_edge2", 32'(out_if.val), 32'd1);
      check_output("single_o_data", 32'(out_if.data), 32'h00A5);
      check_output("single_ae", 32'(almost_empty), 32'd1);
      drain();

      // Fill to full with backpressure, then an extra refused write
      for (int i = 0; i < 16; i++) begin
         apply_stimulus(1'b1, W'(i), 1'b0);
         step();
         check_output("fill_count", 32'(count), 32'(i + 1));
         check_output("fill_af", 32'(almost_full), 32'(i + 1 >= 12));
      end
      check_output("full_i_rdy", 32'(in_if.rdy), 32'd0);
      check_output("full_o_data_head", 32'(out_if.data), 32'd0);
      apply_stimulus(1'b1, 16'd99, 1'b0);
      step();
      check_output("full_count_held", 32'(count), 32'd16);
      start_n = out_n;
      drain();
      check_output("fill_drained_words", 32'(out_n - start_n), 32'd16);

      // Streaming with both sides active
      for (int k = 1; k <= 100; k++) begin
         apply_stimulus(1'b1, W'(1000 + k), 1'b1);
         step();
         if (k >= 2) begin
            check_output("stream_count", 32'(count), 32'd2);
            check_output("stream_o_val", 32'(out_if.val), 32'd1);
         end
      end
      drain();

      // Flush with an output handshake in the flush cycle
      srst = 1'b1;
      step();
      step();
      step();
      srst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b1, W'(200 + i), 1'b0);
         step();
      end
      apply_stimulus(1'b0, '0, 1'b0);
      step();
      check_output("preflush_count", 32'(count), 32'd10);
      check_output("preflush_o_data", 32'(out_if.data), 32'd200);
      flush = 1'b1;
      out_if.rdy = 1'b1;
      #1;
      check_output("flush_i_rdy", 32'(in_if.rdy), 32'd0);
      check_output("flush_o_val", 32'(out_if.val), 32'd1);
      start_n = out_n;
      step();
      flush = 1'b0;
      out_if.rdy = 1'b0;
      #1;
      check_output("flush_delivered", 32'(out_n - start_n), 32'd1);
      check_output("postflush_count", 32'(count), 32'd0);
      check_output("postflush_o_val", 32'(out_if.val), 32'd0);
      check_output("postflush_i_rdy", 32'(in_if.rdy), 32'd1);
`ifdef PARAM_FIFO_HWM_EN
      exp_hwm = 5'd10;
`else
      exp_hwm = 5'd0;
`endif
      check_output("postflush_hwm", 32'(hwm), 32'(exp_hwm));

      // Reset in the middle of traffic
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(1'b1, W'(300 + i), 1'b0);
         step();
      end
      apply_stimulus(1'b0, '0, 1'b0);
      step();
      check_output("midrst_count_before", 32'(count), 32'd7);
      srst = 1'b1;
      step();
      srst = 1'b0;
      #1;
      check_output("midrst_o_val", 32'(out_if.val), 32'd0);
      check_output("midrst_count", 32'(count), 32'd0);
      check_output("midrst_af", 32'(almost_full), 32'd0);
      check_output("midrst_ae", 32'(almost_empty), 32'd1);
      check_output("midrst_hwm", 32'(hwm), 32'd0);
      check_output("midrst_i_rdy", 32'(in_if.rdy), 32'd1);
      apply_stimulus(1'b1, 16'h003C, 1'b0);
      step();
      apply_stimulus(1'b0, '0, 1'b0);
      check_output("midrst_o_val_edge1", 32'(out_if.val), 32'd0);
      step();
      check_output("midrst_o_val_edge2", 32'(out_if.val), 32'd1);
      check_output("midrst_o_data", 32'(out_if.data), 32'h003C);
      check_output("midrst_count_after", 32'(count), 32'd1);
      drain();

      // Random traffic, biased towards filling so both full and empty are exercised
      for (int c = 0; c < 3000; c++) begin
         apply_stimulus(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 9) < 4));
         step();
      end
      drain();
      check_output("queue_empty_end", 32'(exp_q.size()), 32'd0);

      mon_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
